// File: rtl/tt_um_array_divider_hhrb98_pkg.sv
// Shared constants for the restoring array divider: iteration count,
// FSM encoding and the bit positions used on the bidirectional uio bus.
package tt_um_array_divider_hhrb98_pkg;

  localparam int DIV_ITERS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int START_BIT = 4;
  localparam int SEL_BIT   = 5;
  localparam int BUSY_BIT  = 6;
  localparam int DONE_BIT  = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'b1100_0000;

endpackage

// File: rtl/tt_um_array_divider_hhrb98_if.sv
// Tile pin bundle: dedicated inputs, bidirectional inputs, outputs and enables.
interface tt_um_array_divider_hhrb98_if;

  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);

endinterface

// File: rtl/tt_um_array_divider_hhrb98_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module tt_um_array_divider_hhrb98_div_step (
  input  logic [3:0] rem,
  input  logic       dvd_bit,
  input  logic [3:0] divisor,
  output logic [3:0] rem_next,
  output logic       q_bit
);

  logic [4:0] shifted;
  logic [3:0] diff;
  logic       ge;

  // Whenever ge holds the true difference is below 16, so a 4-bit subtract suffices.
  assign shifted  = {rem, dvd_bit};
  assign ge       = (shifted >= {1'b0, divisor});
  assign diff     = shifted[3:0] - divisor;
  assign rem_next = ge ? diff : shifted[3:0];
  assign q_bit    = ge;

endmodule

// File: rtl/tt_um_array_divider_hhrb98.sv
// 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock,
// started by a rising edge on uio_in[4]; result muxed onto uo_out by uio_in[5].
module tt_um_array_divider_hhrb98 #(
  parameter int DIV_ITERS = tt_um_array_divider_hhrb98_pkg::DIV_ITERS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  tt_um_array_divider_hhrb98_if.slave        bus
);

  import tt_um_array_divider_hhrb98_pkg::*;

  localparam int                 CNT_W    = $clog2(DIV_ITERS + 1);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DIV_ITERS - 1);

  state_t           state;
  logic             busy_q, done_q;
  logic             start_q, armed_q;
  logic [7:0]       dvd_q;
  logic [3:0]       dsr_q;
  logic [3:0]       rem_q;
  logic [7:0]       quo_q;
  logic [CNT_W-1:0] cnt;

  logic       start, start_edge;
  logic [3:0] rem_next;
  logic       q_bit;
  logic [7:0] uio_out_w;
  logic       unused_in;

  assign unused_in = &{1'b0, ena, bus.uio_in[7:6]};

  // armed_q blocks a start that was already high when reset was released.
  assign start      = bus.uio_in[START_BIT];
  assign start_edge = start & ~start_q & armed_q;

  tt_um_array_divider_hhrb98_div_step u_div_step (
    .rem      (rem_q),
    .dvd_bit  (dvd_q[7]),
    .divisor  (dsr_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt     <= '0;
    end else begin
      start_q <= start;
      if (!start) armed_q <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state  <= RUN;
            dvd_q  <= bus.ui_in;
            dsr_q  <= bus.uio_in[3:0];
            rem_q  <= '0;
            quo_q  <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          dvd_q <= {dvd_q[6:0], 1'b0};
          quo_q <= {quo_q[6:0], q_bit};
          rem_q <= rem_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            // Divide by zero naturally yields all-ones quotient; force the remainder to match.
            if (dsr_q == 4'd0) rem_q <= 4'hF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    uio_out_w           = '0;
    uio_out_w[BUSY_BIT] = busy_q;
    uio_out_w[DONE_BIT] = done_q;
  end

  assign bus.uo_out  = bus.uio_in[SEL_BIT] ? {4'b0000, rem_q} : quo_q;
  assign bus.uio_out = uio_out_w;
  assign bus.uio_oe  = UIO_OE_VAL;

endmodule
